// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and counter width for the LSU perip master.
package lsu_pkg;
    typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BAD = 2'b11} size_e;
    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ACCESS = 2'b01, ST_RESP = 2'b10} state_e;
    localparam int CNT_W = 4;
endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of lane-aligned load data by access size.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);
    logic sb, sh;
    assign sb = ~uns_i & rdata_i[7];
    assign sh = ~uns_i & rdata_i[15];
    assign ext_o = size_i == SZ_B ? {{24{sb}}, rdata_i[7:0]} :
                   size_i == SZ_H ? {{16{sh}}, rdata_i[15:0]} : rdata_i;
endmodule

// File: rtl/lsu_perip_master.sv
// lsu_perip_master: single-outstanding load/store initiator for the perip/DRAM port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module lsu_perip_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-1:0] perip_addr,
    output logic [31:0]       perip_wdata,
    output logic [1:0]        perip_mask,
    output logic              perip_wen,
    input  logic [31:0]       perip_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, uns_q, err_q;
    size_e             size_q, req_sz;
    logic [ADDR_W-1:0] addr_q, addr_al;
    logic [31:0]       wdata_q, rdata_q, ext;
    logic [4:0]        rd_q;
    logic              bad, accept, in_acc, last, unused_addr_hi;

    assign req_sz         = size_e'(req_size);
    assign unused_addr_hi = ^req_addr[31:ADDR_W];
`ifdef LSU_MISALIGN_TRAP_EN
    assign bad     = req_sz == SZ_BAD || (req_sz == SZ_H && req_addr[0]) ||
                     (req_sz == SZ_W && req_addr[1:0] != 2'b00);
    assign addr_al = req_addr[ADDR_W-1:0];
`else
    logic [1:0] lo_clr;
    assign lo_clr  = req_sz == SZ_W ? 2'b11 : req_sz == SZ_H ? 2'b01 : 2'b00;
    assign bad     = req_sz == SZ_BAD;
    assign addr_al = {req_addr[ADDR_W-1:2], req_addr[1:0] & ~lo_clr};
`endif

    assign accept = state_q == ST_IDLE && req_valid;
    assign in_acc = state_q == ST_ACCESS;
    assign last   = in_acc && cnt_q == '0;

    always_comb begin
        state_d = state_q == ST_IDLE   ? (req_valid ? (bad ? ST_RESP : ST_ACCESS) : ST_IDLE) :
                  state_q == ST_ACCESS ? (last ? ST_RESP : ST_ACCESS) :
                  (resp_ready ? ST_IDLE : ST_RESP);
        cnt_d   = accept ? CNT_W'(WAIT_CYCLES) : (in_acc && !last) ? cnt_q - 1'b1 : cnt_q;
    end

    lsu_load_ext u_ext (
        .rdata_i(perip_rdata),
        .size_i (size_q),
        .uns_i  (uns_q),
        .ext_o  (ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_W;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_sz;
                uns_q   <= req_unsigned;
                addr_q  <= addr_al;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                rdata_q <= '0;
                err_q   <= bad;
            end else if (last) begin
                rdata_q <= we_q ? '0 : ext;
            end
        end
    end

    // Bus is parked (mask = word) outside ACCESS; wen decodes from state so reset kills it at once.
    assign req_ready   = state_q == ST_IDLE;
    assign perip_addr  = in_acc ? addr_q : '0;
    assign perip_wdata = in_acc ? wdata_q : '0;
    assign perip_mask  = in_acc ? size_q : SZ_W;
    assign perip_wen   = last && we_q;
    assign resp_valid  = state_q == ST_RESP;
    assign resp_rdata  = rdata_q;
    assign resp_rd     = rd_q;
    assign resp_err    = err_q;
endmodule
